// File: rtl/s1_decode_stage_if.sv
// Fetch/writeback-to-decode bus and the S1/S2 pipeline outputs for s1_decode_stage.
// master = fetch/writeback side driving the stage, slave = the decode stage itself.
interface s1_decode_stage_if #(
    parameter int N = 32
);
    logic [31:0]  ins;
    logic         ins_valid;
    logic         stall;
    logic         flush;
    logic         wb_en;
    logic [4:0]   wb_addr;
    logic [N-1:0] wb_data;
    logic [N-1:0] R2;
    logic [N-1:0] R3;
    logic [2:0]   S2_ALU_OP;
    logic [4:0]   S2_WA;
    logic         S2_WE;
    logic         S2_valid;
    logic [15:0]  issue_cnt;

    modport master (
        output ins, ins_valid, stall, flush, wb_en, wb_addr, wb_data,
        input  R2, R3, S2_ALU_OP, S2_WA, S2_WE, S2_valid, issue_cnt
    );

    modport slave (
        input  ins, ins_valid, stall, flush, wb_en, wb_addr, wb_data,
        output R2, R3, S2_ALU_OP, S2_WA, S2_WE, S2_valid, issue_cnt
    );
endinterface

// File: rtl/s1_decode_stage.sv
// Stage-1 decode/operand fetch: 32-entry register file plus the S1/S2 pipeline register.
// Optional macro S1_WB_BYPASS_EN forwards same-cycle writeback data onto the operand reads.
module s1_decode_stage #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    s1_decode_stage_if.slave     bus
);
    logic [N-1:0] rf_reg [32];

    logic [1:0]   form;
    logic [2:0]   op;
    logic [4:0]   rd;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [15:0]  imm;
    logic         is_op;
    logic [N-1:0] rs1_val;
    logic [N-1:0] rs2_val;
    logic [N-1:0] imm_ext;

    logic [N-1:0] r2_reg, r2_next;
    logic [N-1:0] r3_reg, r3_next;
    logic [2:0]   op_reg, op_next;
    logic [4:0]   wa_reg, wa_next;
    logic         we_reg, we_next;
    logic         valid_reg, valid_next;
    logic [15:0]  cnt_reg, cnt_next;

    assign form    = bus.ins[31:30];
    assign op      = bus.ins[29:27];
    assign rd      = bus.ins[26:22];
    assign rs1     = bus.ins[21:17];
    assign rs2     = bus.ins[16:12];
    assign imm     = bus.ins[15:0];
    assign is_op   = bus.ins_valid && !form[1];
    assign imm_ext = {{(N-16){imm[15]}}, imm};

    // Entry 0 is never written, but reads are still forced to zero explicitly.
    always_comb begin
        rs1_val = (rs1 == 5'd0) ? '0 : rf_reg[rs1];
        rs2_val = (rs2 == 5'd0) ? '0 : rf_reg[rs2];
`ifdef S1_WB_BYPASS_EN
        if (bus.wb_en && bus.wb_addr != 5'd0 && bus.wb_addr == rs1) rs1_val = bus.wb_data;
        if (bus.wb_en && bus.wb_addr != 5'd0 && bus.wb_addr == rs2) rs2_val = bus.wb_data;
`endif
    end

    // Writeback commits regardless of stall/flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_reg[i] <= '0;
        end else if (bus.wb_en && bus.wb_addr != 5'd0) begin
            rf_reg[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Flush beats stall; a stalled stage with no flush holds everything.
    always_comb begin
        r2_next    = r2_reg;
        r3_next    = r3_reg;
        op_next    = op_reg;
        wa_next    = wa_reg;
        we_next    = we_reg;
        valid_next = valid_reg;
        cnt_next   = cnt_reg;
        if (bus.flush || (!bus.stall && !is_op)) begin
            r2_next    = '0;
            r3_next    = '0;
            op_next    = '0;
            wa_next    = '0;
            we_next    = 1'b0;
            valid_next = 1'b0;
        end else if (!bus.stall) begin
            r2_next    = rs1_val;
            r3_next    = form[0] ? imm_ext : rs2_val;
            op_next    = op;
            wa_next    = rd;
            we_next    = (rd != 5'd0);
            valid_next = 1'b1;
            cnt_next   = cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_reg    <= '0;
            r3_reg    <= '0;
            op_reg    <= '0;
            wa_reg    <= '0;
            we_reg    <= 1'b0;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            r2_reg    <= r2_next;
            r3_reg    <= r3_next;
            op_reg    <= op_next;
            wa_reg    <= wa_next;
            we_reg    <= we_next;
            valid_reg <= valid_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign bus.R2        = r2_reg;
    assign bus.R3        = r3_reg;
    assign bus.S2_ALU_OP = op_reg;
    assign bus.S2_WA     = wa_reg;
    assign bus.S2_WE     = we_reg;
    assign bus.S2_valid  = valid_reg;
    assign bus.issue_cnt = cnt_reg;
endmodule

// File: tb/tb_s1_decode_stage.sv
// Bench for s1_decode_stage: directed scenarios plus randomized traffic against an
// instruction-level reference model of the register file and S1/S2 register.
module tb_s1_decode_stage;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    s1_decode_stage_if #(.N(32)) bus ();

    s1_decode_stage #(.N(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_rf [32];
    logic [31:0] e_r2, e_r3;
    logic [2:0]  e_op;
    logic [4:0]  e_wa;
    logic        e_we, e_v;
    logic [15:0] e_cnt;

    logic [89:0] obs, expv;
    assign obs  = {bus.R2, bus.R3, bus.S2_ALU_OP, bus.S2_WA, bus.S2_WE, bus.S2_valid, bus.issue_cnt};
    assign expv = {e_r2, e_r3, e_op, e_wa, e_we, e_v, e_cnt};

    function automatic logic [31:0] mk_rr(input int op, input int rd, input int rs1, input int rs2);
        logic [31:0] w;
        w = 32'd0;
        w[29:27] = op[2:0]; w[26:22] = rd[4:0]; w[21:17] = rs1[4:0]; w[16:12] = rs2[4:0];
        return w;
    endfunction

    function automatic logic [31:0] mk_ri(input int op, input int rd, input int rs1, input int imm);
        logic [31:0] w;
        w = 32'h4000_0000;
        w[29:27] = op[2:0]; w[26:22] = rd[4:0]; w[21:17] = rs1[4:0]; w[15:0] = imm[15:0];
        return w;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef S1_WB_BYPASS_EN
        if (bus.wb_en && bus.wb_addr == idx) return bus.wb_data;
`endif
        return m_rf[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        e_r2 = 0; e_r3 = 0; e_op = 0; e_wa = 0; e_we = 0; e_v = 0; e_cnt = 0;
    endtask

    task automatic model_bubble();
        e_r2 = 0; e_r3 = 0; e_op = 0; e_wa = 0; e_we = 0; e_v = 0;
    endtask

    // One rising edge's worth of architectural effect, computed from the current inputs.
    task automatic model_edge();
        logic [31:0] w;
        logic        real_ins;
        w = bus.ins;
        real_ins = bus.ins_valid && (w[31:30] == 2'b00 || w[31:30] == 2'b01);
        if (bus.flush) begin
            model_bubble();
        end else if (!bus.stall) begin
            if (real_ins) begin
                e_r2 = model_read(w[21:17]);
                if (w[31:30] == 2'b01)
                    e_r3 = w[15] ? (32'hFFFF_0000 + 32'(w[15:0])) : 32'(w[15:0]);
                else
                    e_r3 = model_read(w[16:12]);
                e_op  = w[29:27];
                e_wa  = w[26:22];
                e_we  = (w[26:22] != 5'd0);
                e_v   = 1'b1;
                e_cnt = e_cnt + 16'd1;
            end else begin
                model_bubble();
            end
        end
        if (bus.wb_en && bus.wb_addr != 5'd0) m_rf[bus.wb_addr] = bus.wb_data;
    endtask

    task automatic drive(input logic [31:0] ins, input logic iv, input logic st, input logic fl,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        bus.ins = ins; bus.ins_valid = iv; bus.stall = st; bus.flush = fl;
        bus.wb_en = we; bus.wb_addr = wa; bus.wb_data = wd;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 90'd0) begin
            errors++; $display("FAIL reset_outputs got=%h want=%h", obs, 90'd0);
        end
        $display("txn reset outputs=%h", obs);
        rst_n = 1'b1;
    endtask

    task automatic test_reg_reg();
        drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h10); cycle();
        drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h3);  cycle();
        drive(mk_rr(3, 4, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0); cycle();
        checks++;
        if ({bus.R2, bus.R3} !== {32'h10, 32'h3}) begin
            errors++; $display("FAIL rr_operands got=%h/%h want=10/3", bus.R2, bus.R3);
        end
        checks++;
        if ({bus.S2_ALU_OP, bus.S2_WA, bus.S2_WE, bus.S2_valid, bus.issue_cnt} !== {3'd3, 5'd4, 1'b1, 1'b1, 16'd1}) begin
            errors++;
            $display("FAIL rr_ctrl got op=%0d wa=%0d we=%0b v=%0b cnt=%0d want 3 4 1 1 1",
                     bus.S2_ALU_OP, bus.S2_WA, bus.S2_WE, bus.S2_valid, bus.issue_cnt);
        end
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL rr_model got=%h want=%h", obs, expv); end
        $display("txn reg_reg R2=%h R3=%h cnt=%0d", bus.R2, bus.R3, bus.issue_cnt);
    endtask

    task automatic test_immediate();
        drive(mk_ri(5, 0, 0, 16'hFFFE), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0); cycle();
        checks++;
        if ({bus.R2, bus.R3, bus.S2_WE, bus.S2_valid} !== {32'd0, 32'hFFFF_FFFE, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL imm_signext got R2=%h R3=%h we=%0b v=%0b want 0 fffffffe 0 1",
                     bus.R2, bus.R3, bus.S2_WE, bus.S2_valid);
        end
        drive(mk_ri(2, 9, 1, 16'h7FFF), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0); cycle();
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL imm_positive got=%h want=%h", obs, expv); end
        $display("txn immediate R2=%h R3=%h cnt=%0d", bus.R2, bus.R3, bus.issue_cnt);
    endtask

    task automatic test_stall_flush();
        drive(mk_rr(6, 12, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0); cycle();
        for (int i = 0; i < 3; i++) begin
            drive(mk_rr(1, 3, 2, 1), 1'b1, 1'b1, 1'b0, 1'b1, 5'd20 + 5'(i), 32'h100 + i); cycle();
            checks++;
            if (obs !== expv || bus.S2_WA !== 5'd12) begin
                errors++; $display("FAIL stall_hold%0d got=%h want=%h", i, obs, expv);
            end
            $display("txn stall%0d wa=%0d cnt=%0d", i, bus.S2_WA, bus.issue_cnt);
        end
        drive(mk_rr(1, 3, 20, 21), 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0); cycle();
        checks++;
        if (obs !== expv || bus.S2_valid !== 1'b0 || bus.R2 !== 32'd0) begin
            errors++; $display("FAIL flush_over_stall got=%h want=%h", obs, expv);
        end
        $display("txn flush+stall valid=%0b cnt=%0d", bus.S2_valid, bus.issue_cnt);
        drive(mk_rr(1, 3, 20, 22), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0); cycle();
        checks++;
        if (obs !== expv || bus.R2 !== 32'h100 || bus.R3 !== 32'h102) begin
            errors++; $display("FAIL after_stall_wb got=%h want=%h", obs, expv);
        end
        $display("txn resume R2=%h R3=%h", bus.R2, bus.R3);
    endtask

    task automatic test_bypass();
        logic [31:0] want;
`ifdef S1_WB_BYPASS_EN
        want = 32'hAA;
`else
        want = 32'h11;
`endif
        drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h11); cycle();
        drive(mk_rr(0, 8, 7, 0), 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'hAA); cycle();
        checks++;
        if (bus.R2 !== want || obs !== expv) begin
            errors++; $display("FAIL bypass_same_cycle got=%h want=%h", bus.R2, want);
        end
        $display("txn bypass R2=%h", bus.R2);
        drive(mk_rr(0, 8, 0, 7), 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEAD); cycle();
        checks++;
        if ({bus.R2, bus.R3} !== {32'd0, 32'hAA}) begin
            errors++; $display("FAIL r0_and_committed got=%h/%h want=0/aa", bus.R2, bus.R3);
        end
        $display("txn r0 R2=%h R3=%h", bus.R2, bus.R3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive($urandom(), ($urandom_range(0, 9) < 8), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 31)), $urandom());
            cycle();
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL random%0d got=%h want=%h", i, obs, expv);
            end
            $display("txn rand%0d ins=%h R2=%h R3=%h op=%0d wa=%0d we=%0b v=%0b cnt=%0d", i,
                     bus.ins, bus.R2, bus.R3, bus.S2_ALU_OP, bus.S2_WA, bus.S2_WE, bus.S2_valid, bus.issue_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h55); cycle();
        drive(mk_rr(4, 6, 5, 5), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0); cycle();
        checks++;
        if (bus.S2_valid !== 1'b1 || bus.R2 !== 32'h55) begin
            errors++; $display("FAIL pre_reset got v=%0b R2=%h want 1 55", bus.S2_valid, bus.R2);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== 90'd0) begin errors++; $display("FAIL async_reset got=%h want=%h", obs, 90'd0); end
        $display("txn async_reset outputs=%h", obs);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        checks++;
        if (bus.R2 !== 32'd0 || bus.R3 !== 32'd0 || bus.S2_valid !== 1'b1 || bus.issue_cnt !== 16'd1) begin
            errors++; $display("FAIL r5_cleared got R2=%h v=%0b cnt=%0d want 0 1 1", bus.R2, bus.S2_valid, bus.issue_cnt);
        end
        $display("txn read_r5 R2=%h cnt=%0d", bus.R2, bus.issue_cnt);
    endtask

    task automatic test_counter_wrap();
        drive(mk_rr(1, 0, 3, 4), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        while (e_cnt != 16'hFFFF) cycle();
        checks++;
        if (bus.issue_cnt !== 16'hFFFF || obs !== expv) begin
            errors++; $display("FAIL cnt_preload got=%h want=ffff", bus.issue_cnt);
        end
        $display("txn preload cnt=%h", bus.issue_cnt);
        cycle();
        checks++;
        if (bus.issue_cnt !== 16'h0000 || obs !== expv) begin
            errors++; $display("FAIL cnt_wrap got=%h want=0000", bus.issue_cnt);
        end
        $display("txn wrap cnt=%h", bus.issue_cnt);
        drive(32'h8000_0000 | mk_rr(1, 5, 3, 4), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0); cycle();
        checks++;
        if (bus.issue_cnt !== 16'h0000 || bus.S2_valid !== 1'b0 || obs !== expv) begin
            errors++; $display("FAIL nop_no_count got cnt=%h v=%0b want 0000 0", bus.issue_cnt, bus.S2_valid);
        end
        drive(mk_rr(1, 5, 3, 4), 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0); cycle();
        checks++;
        if (bus.issue_cnt !== 16'h0000 || bus.S2_valid !== 1'b0) begin
            errors++; $display("FAIL invalid_no_count got cnt=%h v=%0b want 0000 0", bus.issue_cnt, bus.S2_valid);
        end
        $display("txn nop/invalid cnt=%h", bus.issue_cnt);
    endtask

    initial begin
        test_reset();
        test_reg_reg();
        test_immediate();
        test_stall_flush();
        test_bypass();
        test_random();
        test_reset_midstream();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
